// File: rtl/ysyx_24110015_icache_axi_bridge_if.sv
// Bundle of the icache refill port (mem_req_*) and the AXI4 read channels
// (AR/R) seen by the icache AXI bridge.
// The slave modport is the bridge's view. The master modport is the
// environment's view: the cache plus the system bus.
interface ysyx_24110015_icache_axi_bridge_if #(
    parameter int BLOCK_SIZE = 4,
    parameter int ID_WIDTH   = 4
);
    // Cache refill request/response
    logic [31:0]             mem_req_addr;
    logic                    mem_req_valid;
    logic [8*BLOCK_SIZE-1:0] mem_req_data;
    logic                    mem_req_ready;
    logic                    mem_req_err;

    // AXI4 read-address channel
    logic [31:0]             araddr;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     arid;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;

    // AXI4 read-data channel
    logic [8*BLOCK_SIZE-1:0] rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;
    logic                    rlast;
    logic [ID_WIDTH-1:0]     rid;

    modport slave (
        input  mem_req_addr, mem_req_valid,
        output mem_req_data, mem_req_ready, mem_req_err,
        output araddr, arvalid, arid, arlen, arsize, arburst,
        input  arready,
        input  rdata, rresp, rvalid, rlast, rid,
        output rready
    );

    modport master (
        output mem_req_addr, mem_req_valid,
        input  mem_req_data, mem_req_ready, mem_req_err,
        input  araddr, arvalid, arid, arlen, arsize, arburst,
        output arready,
        output rdata, rresp, rvalid, rlast, rid,
        input  rready
    );
endinterface

// File: rtl/ysyx_24110015_icache_axi_bridge.sv
// Icache refill responder. It turns one cache block-fetch request into a
// single-beat AXI4 read and returns the block with a one-cycle ready pulse.
// Every bus-facing control output is decoded from the registered state, so
// no input reaches an output combinationally. The block also keeps
// fetch and stall statistics.
module ysyx_24110015_icache_axi_bridge #(
    parameter int BLOCK_SIZE = 4,
    parameter int ID         = 0,
    parameter int ID_WIDTH   = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    ysyx_24110015_icache_axi_bridge_if.slave        bus,
    output logic [31:0]                             fetch_cnt,
    output logic [31:0]                             stall_cnt
);
    localparam int DW = 8 * BLOCK_SIZE;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     addr_q,  addr_d;
    logic [DW-1:0]   data_q,  data_d;
    logic            err_q,   err_d;
    logic [31:0]     fetch_cnt_q, fetch_cnt_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;

    // Only the error bit of the response matters. OKAY and EXOKAY both mean success.
    logic            unused_rresp_lsb;
    assign unused_rresp_lsb = bus.rresp[0];

    // Fixed AXI attributes: single beat, full-width, incrementing burst
    assign bus.arid    = ID_WIDTH'(ID);
    assign bus.arlen   = 8'd0;
    assign bus.arsize  = 3'($clog2(BLOCK_SIZE));
    assign bus.arburst = 2'b01;
    // addr_q only changes in IDLE, so the address is stable for the whole AR phase.
    assign bus.araddr  = addr_q;

    assign fetch_cnt   = fetch_cnt_q;
    assign stall_cnt   = stall_cnt_q;

    // Next-state logic and outputs decoded from the registered state.
    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        data_d            = data_q;
        err_d             = err_q;
        bus.arvalid       = 1'b0;
        bus.rready        = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_req_data  = '0;
        bus.mem_req_err   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.mem_req_valid) begin
                    addr_d  = bus.mem_req_addr;
                    state_d = S_AR;
                end
            end
            S_AR: begin
                bus.arvalid = 1'b1;
                if (bus.arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                bus.rready = 1'b1;
                // Single-beat burst: every beat is the last one.
                if (bus.rvalid) begin
                    data_d  = bus.rdata;
                    err_d   = bus.rresp[1];
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                // data_q cannot change in RESP, so the cache sees a stable line
                // when it writes on valid & ready.
                bus.mem_req_ready = 1'b1;
                bus.mem_req_data  = data_q;
                bus.mem_req_err   = err_q;
                state_d           = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Statistics: completed fetches, and cycles spent waiting on the bus.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (state_q == S_RESP) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if ((state_q == S_AR) || (state_q == S_R)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // State and datapath registers. Reset abandons any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            err_q       <= err_d;
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

`ifndef SYNTHESIS
    // The slave must return exactly one beat carrying our own ID.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == S_R) && bus.rvalid) begin
            assert (bus.rlast && (bus.rid == ID_WIDTH'(ID)));
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_24110015_icache_axi_bridge.sv
module tb_ysyx_24110015_icache_axi_bridge;
    localparam int BLOCK_SIZE = 4;
    localparam int ID         = 0;
    localparam int ID_WIDTH   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    ysyx_24110015_icache_axi_bridge_if #(.BLOCK_SIZE(BLOCK_SIZE), .ID_WIDTH(ID_WIDTH)) bus ();

    ysyx_24110015_icache_axi_bridge #(
        .BLOCK_SIZE(BLOCK_SIZE),
        .ID        (ID),
        .ID_WIDTH  (ID_WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .fetch_cnt(fetch_cnt),
        .stall_cnt(stall_cnt)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    // Slave configuration
    int          ar_delay   = 0;
    int          r_delay    = 0;
    bit          use_fixed  = 0;
    logic [31:0] fixed_data = 32'h0;
    logic [1:0]  resp_cfg   = 2'b00;

    // Monitor state
    int          arv_cyc   = -1;
    logic [31:0] arv_addr  = 32'h0;
    bit          arv_prev  = 0;
    int          ready_cnt = 0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_1234;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // AXI slave model with configurable wait states
    int          ar_cnt = 0;
    int          r_cnt  = 0;
    logic [31:0] ar_first_addr = 32'h0;
    logic [31:0] acc_addr = 32'h0;
    always @(negedge clk) begin
        if (rst) begin
            bus.arready = 1'b0;
            bus.rvalid  = 1'b0;
            bus.rdata   = '0;
            bus.rresp   = 2'b00;
            bus.rlast   = 1'b1;
            bus.rid     = ID_WIDTH'(ID);
            ar_cnt      = 0;
            r_cnt       = 0;
        end else begin
            if (bus.arvalid) begin
                if (ar_cnt == 0) ar_first_addr = bus.araddr;
                else check("araddr_stable", bus.araddr, ar_first_addr);
                if (ar_cnt >= ar_delay) begin
                    bus.arready = 1'b1;
                    acc_addr    = bus.araddr;
                end else begin
                    bus.arready = 1'b0;
                end
                ar_cnt++;
            end else begin
                bus.arready = 1'b0;
                ar_cnt      = 0;
            end
            if (bus.rready) begin
                if (r_cnt >= r_delay) begin
                    bus.rvalid = 1'b1;
                    bus.rdata  = use_fixed ? fixed_data : mem_fn(acc_addr);
                    bus.rresp  = resp_cfg;
                end else begin
                    bus.rvalid = 1'b0;
                end
                r_cnt++;
            end else begin
                bus.rvalid = 1'b0;
                r_cnt      = 0;
            end
            if (bus.arvalid || bus.rready)
                check("no_ar_r_overlap", bus.arvalid & bus.rready, 1'b0);
        end
    end

    // Output monitor: pops the scoreboard on every ready pulse
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            arv_prev = 0;
        end else begin
            if (bus.arvalid && !arv_prev) begin
                arv_cyc  = cyc;
                arv_addr = bus.araddr;
            end
            arv_prev = bus.arvalid;
            if (bus.mem_req_ready) begin
                ready_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_ready", bus.mem_req_ready, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("resp_data", bus.mem_req_data, e.data);
                    check("resp_err", bus.mem_req_err, e.err);
                end
            end
        end
    end

    task automatic wait_ready(output int rc, output logic [31:0] got);
        rc  = -1;
        got = '0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.mem_req_ready === 1'b1) begin
                rc  = cyc;
                got = bus.mem_req_data;
                break;
            end
        end
        check("ready_seen", (rc >= 0), 1'b1);
    endtask

    task automatic do_req(input logic [31:0] addr, input logic [31:0] ed, input logic ee,
                          output int c0, output int rc, output logic [31:0] got);
        @(negedge clk);
        #1;
        c0 = cyc;
        bus.mem_req_addr  = addr;
        bus.mem_req_valid = 1'b1;
        sb.push_back('{data: ed, err: ee});
        wait_ready(rc, got);
        @(posedge clk);
        #1;
        bus.mem_req_valid = 1'b0;
        @(negedge clk);
        check("ready_one_cycle", bus.mem_req_ready, 1'b0);
        check("err_low_after", bus.mem_req_err, 1'b0);
    endtask

    initial begin
        int          c0, rc, r1, r2, pulses0;
        logic [31:0] got, s0, f0;
        logic [31:0] cdata [4];
        logic [31:0] ctag  [4];
        bit          cv    [4];

        bus.mem_req_valid = 1'b0;
        bus.mem_req_addr  = 32'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_arvalid", bus.arvalid, 1'b0);
        check("rst_rready", bus.rready, 1'b0);
        check("rst_ready", bus.mem_req_ready, 1'b0);
        check("rst_err", bus.mem_req_err, 1'b0);
        check("rst_fetch_cnt", fetch_cnt, 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_araddr", bus.araddr, 32'd0);
        #1 rst = 1'b0;

        // Single fetch, zero-wait slave
        use_fixed = 1; fixed_data = 32'h0000_0413; resp_cfg = 2'b00;
        do_req(32'h8000_0004, 32'h0000_0413, 1'b0, c0, rc, got);
        check("t1_latency", rc - c0, 3);
        check("t1_arvalid_cycle", arv_cyc - c0, 1);
        check("t1_araddr", arv_addr, 32'h8000_0004);
        check("t1_arsize", bus.arsize, 3'd2);
        check("t1_arlen", bus.arlen, 8'd0);
        check("t1_arburst", bus.arburst, 2'b01);
        check("t1_arid", bus.arid, ID_WIDTH'(ID));
        check("t1_data", got, 32'h0000_0413);
        check("t1_fetch_cnt", fetch_cnt, 32'd1);
        check("t1_stall_cnt", stall_cnt, 32'd2);

        // Wait states on both channels
        use_fixed = 0; ar_delay = 3; r_delay = 5;
        s0 = stall_cnt;
        do_req(32'h8000_0020, mem_fn(32'h8000_0020), 1'b0, c0, rc, got);
        check("t2_latency", rc - c0, 11);
        check("t2_stall_delta", stall_cnt - s0, 32'd10);
        check("t2_fetch_cnt", fetch_cnt, 32'd2);
        ar_delay = 0; r_delay = 0;

        // Error response
        use_fixed = 1; fixed_data = 32'hDEAD_BEEF; resp_cfg = 2'b10;
        do_req(32'h8000_0030, 32'hDEAD_BEEF, 1'b1, c0, rc, got);
        check("t3_data", got, 32'hDEAD_BEEF);
        use_fixed = 0; resp_cfg = 2'b00;

        // Back-to-back requests
        @(negedge clk);
        #1;
        bus.mem_req_addr  = 32'h8000_0004;
        bus.mem_req_valid = 1'b1;
        sb.push_back('{data: mem_fn(32'h8000_0004), err: 1'b0});
        wait_ready(r1, got);
        @(posedge clk);
        #1;
        bus.mem_req_addr = 32'h8000_0008;
        sb.push_back('{data: mem_fn(32'h8000_0008), err: 1'b0});
        wait_ready(r2, got);
        check("t4_second_arvalid", arv_cyc - r1, 2);
        check("t4_second_araddr", arv_addr, 32'h8000_0008);
        check("t4_throughput", r2 - r1, 4);
        @(posedge clk);
        #1;
        bus.mem_req_valid = 1'b0;

        // Asynchronous reset while waiting in R
        r_delay = 20;
        @(negedge clk);
        #1;
        bus.mem_req_addr  = 32'h8000_0040;
        bus.mem_req_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.rready === 1'b1) break;
        end
        check("t5_in_r", bus.rready, 1'b1);
        pulses0 = ready_cnt;
        #2;
        rst = 1'b1;
        bus.mem_req_valid = 1'b0;
        #1;
        check("t5_rready", bus.rready, 1'b0);
        check("t5_arvalid", bus.arvalid, 1'b0);
        check("t5_ready", bus.mem_req_ready, 1'b0);
        check("t5_fetch_cnt", fetch_cnt, 32'd0);
        check("t5_stall_cnt", stall_cnt, 32'd0);
        check("t5_araddr", bus.araddr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        r_delay = 0;
        repeat (3) @(negedge clk);
        check("t5_no_pulse", ready_cnt, pulses0);
        check("t5_sb_empty", sb.size(), 0);
        do_req(32'h8000_0044, mem_fn(32'h8000_0044), 1'b0, c0, rc, got);
        check("t5_after_latency", rc - c0, 3);
        check("t5_after_fetch_cnt", fetch_cnt, 32'd1);

        // Small direct-mapped cache running a 4-instruction loop twice
        for (int i = 0; i < 4; i++) cv[i] = 0;
        f0 = fetch_cnt;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 4; i++) begin
                logic [31:0] a;
                a = 32'h8000_0100 + 32'(4 * i);
                if (!cv[i] || ctag[i] != a) begin
                    do_req(a, mem_fn(a), 1'b0, c0, rc, got);
                    cv[i]    = 1;
                    ctag[i]  = a;
                    cdata[i] = got;
                end
                check("t6_cache_out", cdata[i], mem_fn(a));
            end
        end
        check("t6_fetch_delta", fetch_cnt - f0, 32'd4);

        repeat (2) @(negedge clk);
        check("final_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
